// File: rtl/mw_timer_pkg.sv
// Shared encodings for the microwave mm:ss countdown controller.
package mw_timer_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Update applied to the mm:ss value registers on the next edge
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_DEC   = 3'd3,
    OP_ADD   = 3'd4
  } val_op_e;

  localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/mmss_arith.sv
// Combinational mm:ss arithmetic: decrement with borrow, add with carry and
// saturation, and load-value clamping.
module mmss_arith
  import mw_timer_pkg::*;
#(
  parameter int unsigned MIN_W    = 7,
  parameter int unsigned MAX_MIN  = 99,
  parameter int unsigned ADD_STEP = 30
) (
  input  logic [MIN_W-1:0] cur_min_i,
  input  logic [5:0]       cur_sec_i,
  input  logic [MIN_W-1:0] raw_min_i,
  input  logic [5:0]       raw_sec_i,
  output logic [MIN_W-1:0] dec_min_o,
  output logic [5:0]       dec_sec_o,
  output logic             dec_zero_o,
  output logic [MIN_W-1:0] add_min_o,
  output logic [5:0]       add_sec_o,
  output logic [MIN_W-1:0] ld_min_o,
  output logic [5:0]       ld_sec_o
);

  localparam int unsigned       SUM_W   = MIN_W + 1;
  localparam logic [MIN_W-1:0]  MIN_ONE = MIN_W'(1);
  localparam logic [MIN_W-1:0]  MIN_CAP = MIN_W'(MAX_MIN);
  localparam logic [SUM_W-1:0]  SUM_CAP = SUM_W'(MAX_MIN);
  localparam logic [6:0]        STEP    = 7'(ADD_STEP);

  logic [6:0]       sum_sec;
  logic             carry;
  logic [SUM_W-1:0] sum_min;

  // One-second decrement; holds at 0:00 so the value can never underflow
  always_comb begin
    dec_min_o = cur_min_i;
    dec_sec_o = cur_sec_i;
    if (cur_sec_i != '0) begin
      dec_sec_o = cur_sec_i - 6'd1;
    end else if (cur_min_i != '0) begin
      dec_sec_o = SEC_MAX;
      dec_min_o = cur_min_i - MIN_ONE;
    end
    dec_zero_o = (dec_min_o == '0) && (dec_sec_o == '0);
  end

  // Extension by ADD_STEP seconds; seconds wrap mod 60, overflow past MAX_MIN pins to MAX_MIN:59
  always_comb begin
    sum_sec = {1'b0, cur_sec_i} + STEP;
    carry   = (sum_sec >= 7'd60);
    sum_min = {1'b0, cur_min_i} + SUM_W'(carry);
    if (carry) begin
      add_sec_o = 6'(sum_sec - 7'd60);
    end else begin
      add_sec_o = sum_sec[5:0];
    end
    if (sum_min > SUM_CAP) begin
      add_min_o = MIN_CAP;
      add_sec_o = SEC_MAX;
    end else begin
      add_min_o = sum_min[MIN_W-1:0];
    end
  end

  // Clamp a raw load value into the legal display range field by field
  always_comb begin
    ld_sec_o = (raw_sec_i > SEC_MAX) ? SEC_MAX : raw_sec_i;
    ld_min_o = (raw_min_i > MIN_CAP) ? MIN_CAP : raw_min_i;
  end

endmodule

// File: rtl/mw_preset_timer_ctrl.sv
// Microwave mm:ss countdown controller: switch/preset load, 1 Hz countdown,
// pause/resume, cancel, +ADD_STEP extension and done flagging.
module mw_preset_timer_ctrl
  import mw_timer_pkg::*;
#(
  parameter int unsigned                  MIN_W      = 7,
  parameter int unsigned                  MAX_MIN    = 99,
  parameter int unsigned                  N_PRESETS  = 4,
  parameter int unsigned                  PSEL_W     = 2,
  parameter logic [N_PRESETS*MIN_W-1:0]   PRESET_MIN = {7'd10, 7'd2, 7'd5, 7'd2},
  parameter logic [N_PRESETS*6-1:0]       PRESET_SEC = {6'd0, 6'd30, 6'd0, 6'd0},
  parameter int unsigned                  ADD_STEP   = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic              preset_en,
  input  logic [PSEL_W-1:0] preset_sel,
  input  logic [MIN_W-1:0]  load_minutes,
  input  logic [5:0]        load_seconds,
  input  logic              start,
  input  logic              pause,
  input  logic              cancel,
  input  logic              add30,
  output logic [MIN_W-1:0]  minutes,
  output logic [5:0]        seconds,
  output logic              running,
  output logic              paused,
  output logic              timer_end,
  output logic              done
);

  state_e           state_q, state_d;
  val_op_e          op;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             running_q, running_d;
  logic             paused_q, paused_d;
  logic             timer_end_q, timer_end_d;
  logic             done_q, done_d;

  logic [MIN_W-1:0] raw_min, dec_min, add_min, ld_min;
  logic [5:0]       raw_sec, dec_sec, add_sec, ld_sec;
  logic             dec_zero;
  logic             cur_zero;

  assign cur_zero = (min_q == '0) && (sec_q == '0);

  // Select load source; an index with no table entry loads 0:00
  always_comb begin
    raw_min = load_minutes;
    raw_sec = load_seconds;
    if (preset_en) begin
      raw_min = '0;
      raw_sec = '0;
      for (int unsigned i = 0; i < N_PRESETS; i++) begin
        if (preset_sel == PSEL_W'(i)) begin
          raw_min = PRESET_MIN[i*MIN_W +: MIN_W];
          raw_sec = PRESET_SEC[i*6 +: 6];
        end
      end
    end
  end

  mmss_arith #(
    .MIN_W    (MIN_W),
    .MAX_MIN  (MAX_MIN),
    .ADD_STEP (ADD_STEP)
  ) u_arith (
    .cur_min_i  (min_q),
    .cur_sec_i  (sec_q),
    .raw_min_i  (raw_min),
    .raw_sec_i  (raw_sec),
    .dec_min_o  (dec_min),
    .dec_sec_o  (dec_sec),
    .dec_zero_o (dec_zero),
    .add_min_o  (add_min),
    .add_sec_o  (add_sec),
    .ld_min_o   (ld_min),
    .ld_sec_o   (ld_sec)
  );

  // State, value and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      min_q       <= '0;
      sec_q       <= '0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      timer_end_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      running_q   <= running_d;
      paused_q    <= paused_d;
      timer_end_q <= timer_end_d;
      done_q      <= done_d;
    end
  end

  // Next state and value operation; priority cancel > load > pause > start > add30 > tick,
  // with inputs that have no meaning in the current state treated as absent
  always_comb begin
    state_d = state_q;
    op      = OP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          op = OP_CLEAR;
        end else if (load) begin
          op = OP_LOAD;
        end else if (start && !cur_zero) begin
          state_d = ST_RUN;
        end else if (add30) begin
          op = OP_ADD;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          op      = OP_CLEAR;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (add30) begin
          op = OP_ADD;
        end else if (tick) begin
          op = OP_DEC;
          if (dec_zero) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (cancel) begin
          state_d = ST_IDLE;
          op      = OP_CLEAR;
        end else if (start) begin
          state_d = ST_RUN;
        end else if (add30) begin
          op = OP_ADD;
        end
      end
      ST_DONE: begin
        if (cancel) begin
          state_d = ST_IDLE;
          op      = OP_CLEAR;
        end else if (load) begin
          state_d = ST_IDLE;
          op      = OP_LOAD;
        end else if (start) begin
          state_d = ST_IDLE;
          op      = OP_CLEAR;
        end else if (add30) begin
          // value is 0:00 here, so the add yields 0:ADD_STEP
          state_d = ST_RUN;
          op      = OP_ADD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op      = OP_CLEAR;
      end
    endcase
  end

  // Next value and status flags, registered so every output comes from a flop
  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    case (op)
      OP_LOAD: begin
        min_d = ld_min;
        sec_d = ld_sec;
      end
      OP_CLEAR: begin
        min_d = '0;
        sec_d = '0;
      end
      OP_DEC: begin
        min_d = dec_min;
        sec_d = dec_sec;
      end
      OP_ADD: begin
        min_d = add_min;
        sec_d = add_sec;
      end
      default: begin
        min_d = min_q;
        sec_d = sec_q;
      end
    endcase
    running_d   = (state_d == ST_RUN);
    paused_d    = (state_d == ST_PAUSE);
    done_d      = (state_d == ST_DONE);
    timer_end_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign running   = running_q;
  assign paused    = paused_q;
  assign timer_end = timer_end_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mw_preset_timer_ctrl.sv
// Bench for mw_preset_timer_ctrl: a total-seconds reference model pushes the
// expected outputs for each driven cycle; they are popped and compared after the edge.
module tb_mw_preset_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, preset_en = 1'b0;
  logic       start = 1'b0, pause = 1'b0, cancel = 1'b0, add30 = 1'b0;
  logic [1:0] preset_sel = '0;
  logic [6:0] load_minutes = '0;
  logic [5:0] load_seconds = '0;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running, paused, timer_end, done;

  mw_preset_timer_ctrl #(
    .MIN_W    (7),
    .MAX_MIN  (99),
    .N_PRESETS(4),
    .PSEL_W   (2),
    .ADD_STEP (30)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .load         (load),
    .preset_en    (preset_en),
    .preset_sel   (preset_sel),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds),
    .start        (start),
    .pause        (pause),
    .cancel       (cancel),
    .add30        (add30),
    .minutes      (minutes),
    .seconds      (seconds),
    .running      (running),
    .paused       (paused),
    .timer_end    (timer_end),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned mm;
    int unsigned ss;
    int unsigned run;
    int unsigned pau;
    int unsigned tend;
    int unsigned dn;
  } exp_t;

  localparam int          M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam int unsigned CAP    = 99 * 60 + 59;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_st = M_IDLE;
  int unsigned m_tot = 0;
  int unsigned tend_seen = 0;
  int unsigned pre_min[4] = '{2, 5, 2, 10};
  int unsigned pre_sec[4] = '{0, 0, 30, 0};

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned sat_add(input int unsigned t);
    return (t + 30 > CAP) ? CAP : t + 30;
  endfunction

  // Reference model: advance one edge using the currently driven inputs
  task automatic model_step();
    int unsigned lm, ls, nt;
    int          ns;
    exp_t        e;
    if (preset_en) begin
      lm = pre_min[preset_sel];
      ls = pre_sec[preset_sel];
    end else begin
      lm = load_minutes;
      ls = load_seconds;
    end
    if (lm > 99) lm = 99;
    if (ls > 59) ls = 59;
    ns     = m_st;
    nt     = m_tot;
    e.tend = 0;
    case (m_st)
      M_IDLE: begin
        if (cancel)                  nt = 0;
        else if (load)               nt = lm * 60 + ls;
        else if (start && nt != 0)   ns = M_RUN;
        else if (add30)              nt = sat_add(nt);
      end
      M_RUN: begin
        if (cancel) begin
          ns = M_IDLE; nt = 0;
        end else if (pause) begin
          ns = M_PAUSE;
        end else if (add30) begin
          nt = sat_add(nt);
        end else if (tick && nt != 0) begin
          nt = nt - 1;
          if (nt == 0) begin
            ns = M_DONE; e.tend = 1;
          end
        end
      end
      M_PAUSE: begin
        if (cancel) begin
          ns = M_IDLE; nt = 0;
        end else if (start) begin
          ns = M_RUN;
        end else if (add30) begin
          nt = sat_add(nt);
        end
      end
      default: begin
        if (cancel)      begin ns = M_IDLE; nt = 0; end
        else if (load)   begin ns = M_IDLE; nt = lm * 60 + ls; end
        else if (start)  begin ns = M_IDLE; nt = 0; end
        else if (add30)  begin ns = M_RUN;  nt = 30; end
      end
    endcase
    m_st  = ns;
    m_tot = nt;
    e.mm  = nt / 60;
    e.ss  = nt % 60;
    e.run = (ns == M_RUN)   ? 1 : 0;
    e.pau = (ns == M_PAUSE) ? 1 : 0;
    e.dn  = (ns == M_DONE)  ? 1 : 0;
    sbq.push_back(e);
  endtask

  // One clock with the currently driven pulses, then compare against the scoreboard
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_eq("minutes",   minutes,   e.mm);
    check_eq("seconds",   seconds,   e.ss);
    check_eq("running",   running,   e.run);
    check_eq("paused",    paused,    e.pau);
    check_eq("timer_end", timer_end, e.tend);
    check_eq("done",      done,      e.dn);
    if (timer_end) tend_seen++;
    {tick, load, start, pause, cancel, add30} = '0;
  endtask

  task automatic sw_load(input int unsigned m, input int unsigned s);
    preset_en    = 1'b0;
    load_minutes = 7'(m);
    load_seconds = 6'(s);
    load         = 1'b1;
    cycle();
  endtask

  task automatic pre_load(input int unsigned sel);
    preset_en  = 1'b1;
    preset_sel = 2'(sel);
    load       = 1'b1;
    cycle();
    preset_en  = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_min"},  minutes,   0);
    check_eq({tag, "_sec"},  seconds,   0);
    check_eq({tag, "_run"},  running,   0);
    check_eq({tag, "_pau"},  paused,    0);
    check_eq({tag, "_tend"}, timer_end, 0);
    check_eq({tag, "_done"}, done,      0);
  endtask

  initial begin
    // Reset state, before and after clock edges
    #2;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_held");
    rst = 1'b0;

    // 1: 1:05 countdown to done
    sw_load(1, 5);
    start = 1'b1; cycle();
    tend_seen = 0;
    ticks(65);
    check_eq("t1_tend_count", tend_seen, 1);
    check_eq("t1_done", done, 1);
    ticks(2);

    // 5: DONE + add30 -> RUN 0:30, run out, then load 3:00 from DONE
    add30 = 1'b1; cycle();
    check_eq("t5_add_sec", seconds, 30);
    ticks(30);
    sw_load(3, 0);
    check_eq("t5_load_done", done, 0);
    cancel = 1'b1; cycle();
    start = 1'b1; cycle();
    check_eq("t5_start_zero_run", running, 0);

    // DONE + start -> IDLE at 0:00
    sw_load(0, 1);
    start = 1'b1; cycle();
    ticks(1);
    start = 1'b1; cycle();

    // Preset table entries
    for (int unsigned k = 0; k < 4; k++) pre_load(k);

    // 2: popcorn preset, pause/resume, add30 while paused, cancel from PAUSE
    pre_load(2);
    start = 1'b1; cycle();
    ticks(3);
    pause = 1'b1; cycle();
    ticks(5);
    check_eq("t2_pause_min", minutes, 2);
    check_eq("t2_pause_sec", seconds, 27);
    start = 1'b1; cycle();
    ticks(1);
    check_eq("t2_resume_sec", seconds, 26);
    pause = 1'b1; cycle();
    add30 = 1'b1; cycle();
    load_minutes = 7'd9; load = 1'b1; cycle();
    cancel = 1'b1; cycle();

    // 3: saturation of add30 and load clamp
    sw_load(98, 45);
    for (int unsigned k = 0; k < 3; k++) begin
      add30 = 1'b1; cycle();
    end
    check_eq("t3_sat_min", minutes, 99);
    check_eq("t3_sat_sec", seconds, 59);
    sw_load(0, 0);
    sw_load(120, 75);
    sw_load(7, 75);

    // 4: tick and add30 together, then cancel and start together
    sw_load(0, 40);
    start = 1'b1; cycle();
    tick = 1'b1; add30 = 1'b1; cycle();
    check_eq("t4_net_add", minutes * 60 + seconds, 70);
    load = 1'b1; load_minutes = 7'd4; start = 1'b1; cycle();
    ticks(3);
    cancel = 1'b1; start = 1'b1; cycle();

    // 6: asynchronous reset mid-count
    sw_load(5, 0);
    start = 1'b1; cycle();
    ticks(2);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    m_st  = M_IDLE;
    m_tot = 0;
    @(posedge clk);
    #1;
    check_all_zero("t6_held");
    rst = 1'b0;
    ticks(4);
    sw_load(0, 3);
    start = 1'b1; cycle();
    ticks(4);

    check_eq("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
